// File: rtl/multi_timer_pkg.sv
// rtl/multi_timer_pkg.sv - register offsets, ctrl bit indices and channel ctrl type for multi_timer
package multi_timer_pkg;

    localparam logic [7:0] OFF_INT_LO = 8'd0;
    localparam logic [7:0] OFF_INT_HI = 8'd1;
    localparam logic [7:0] OFF_CTRL   = 8'd2;
    localparam logic [7:0] OFF_COUNT  = 8'd3;
    localparam logic [7:0] OFF_STATUS = 8'd16;
    localparam logic [7:0] OFF_CNTHI  = 8'd17;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_PER = 1;
    localparam int CTRL_IE  = 2;

    typedef struct packed {
        logic ie;
        logic per;
        logic en;
    } ch_ctrl_t;

endpackage

// File: rtl/multi_timer_ch.sv
// rtl/multi_timer_ch.sv - one 16-bit interval counter channel: interval, ctrl, count and fire
module multi_timer_ch
    import multi_timer_pkg::*;
#(
    parameter logic [15:0] INIT_INTERVAL = 16'd0,
    parameter logic [2:0]  INIT_CTRL     = 3'b000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        i_tick,
    input  logic        i_wr_int_lo,
    input  logic        i_wr_int_hi,
    input  logic        i_wr_ctrl,
    input  logic        i_wr_count,
    input  logic [7:0]  i_wdata,
    output logic [15:0] o_interval,
    output ch_ctrl_t    o_ctrl,
    output logic [15:0] o_count,
    output logic        o_fire
);

    logic [15:0] r_interval;
    logic [15:0] r_count;
    ch_ctrl_t    r_ctrl;
    logic        w_active;
    logic [15:0] w_count_inc;

    // The 16-bit increment wraps naturally, so an interval at or below count only fires after 16'hFFFF->0.
    assign w_active    = i_tick && r_ctrl.en && (r_interval != 16'd0);
    assign w_count_inc = r_count + 16'd1;
    assign o_fire      = w_active && (w_count_inc == r_interval);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_interval <= INIT_INTERVAL;
            r_ctrl     <= ch_ctrl_t'(INIT_CTRL);
            r_count    <= 16'd0;
        end else begin
            if (o_fire) begin
                r_count <= 16'd0;
                if (!r_ctrl.per)
                    r_ctrl.en <= 1'b0;
            end else if (w_active) begin
                r_count <= w_count_inc;
            end
            // Bus writes land after the tick update so software always has the last word.
            if (i_wr_int_lo)
                r_interval[7:0] <= i_wdata;
            if (i_wr_int_hi)
                r_interval[15:8] <= i_wdata;
            if (i_wr_ctrl) begin
                r_ctrl.en  <= i_wdata[CTRL_EN];
                r_ctrl.per <= i_wdata[CTRL_PER];
                r_ctrl.ie  <= i_wdata[CTRL_IE];
            end
            if (i_wr_count)
                r_count <= 16'd0;
        end
    end

    assign o_interval = r_interval;
    assign o_ctrl     = r_ctrl;
    assign o_count    = r_count;

endmodule

// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - multi-channel bus timer: prescaler, decode, pending/irq, read mux and tristate
// Define MTIMER_SNAPSHOT_EN to latch count[15:8] on each +3 read for a coherent 16-bit read at BASE+17.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR     = 8'hE0,
    parameter int          NUM_CH        = 4,
    parameter int          CLK_DIV       = 100000,
    parameter logic [15:0] INIT_INTERVAL = 16'd100
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);

    localparam int         PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [3:0] CH_MASK = 4'((1 << NUM_CH) - 1);

    logic [PW-1:0] r_presc;
    logic          w_tick;
    logic [7:0]    w_off;
    logic [1:0]    w_ch;
    logic [1:0]    w_reg;
    logic          w_ch_space;
    logic          w_mapped;
    logic          w_wr_ch;
    logic          w_rd;
    logic [15:0]   w_interval [4];
    ch_ctrl_t      w_ctrl [4];
    logic [15:0]   w_count [4];
    logic [3:0]    w_fire;
    logic [3:0]    w_ie;
    logic [3:0]    w_ack_clr;
    logic [3:0]    w_stat_clr;
    logic [3:0]    r_pending;
    logic          r_raise;
    logic          r_rd_en;
    logic [7:0]    r_rd_data;
    logic [7:0]    w_rd_mux;
    logic [7:0]    w_cnthi;

    assign w_tick = (r_presc == PW'(CLK_DIV - 1));

    always_ff @(posedge CLK) begin
        if (RESET || w_tick)
            r_presc <= '0;
        else
            r_presc <= r_presc + PW'(1);
    end

    // Offset arithmetic wraps, so addresses below BASE_ADDR land far outside the window.
    assign w_off      = BUS_ADDR - BASE_ADDR;
    assign w_ch       = w_off[3:2];
    assign w_reg      = w_off[1:0];
    assign w_ch_space = (w_off < OFF_STATUS);
    assign w_mapped   = w_ch_space ? CH_MASK[w_ch] : (w_off <= OFF_CNTHI);
    assign w_wr_ch    = BUS_WE && w_ch_space && CH_MASK[w_ch];
    assign w_rd       = !BUS_WE && w_mapped;

    for (genvar c = 0; c < 4; c++) begin : g_ch
        if (c < NUM_CH) begin : g_on
            multi_timer_ch #(
                .INIT_INTERVAL((c == 0) ? INIT_INTERVAL : 16'd0),
                .INIT_CTRL    ((c == 0) ? 3'b111 : 3'b000)
            ) u_ch (
                .CLK         (CLK),
                .RESET       (RESET),
                .i_tick      (w_tick),
                .i_wr_int_lo (w_wr_ch && (w_ch == 2'(c)) && (w_reg == OFF_INT_LO[1:0])),
                .i_wr_int_hi (w_wr_ch && (w_ch == 2'(c)) && (w_reg == OFF_INT_HI[1:0])),
                .i_wr_ctrl   (w_wr_ch && (w_ch == 2'(c)) && (w_reg == OFF_CTRL[1:0])),
                .i_wr_count  (w_wr_ch && (w_ch == 2'(c)) && (w_reg == OFF_COUNT[1:0])),
                .i_wdata     (BUS_DATA),
                .o_interval  (w_interval[c]),
                .o_ctrl      (w_ctrl[c]),
                .o_count     (w_count[c]),
                .o_fire      (w_fire[c])
            );
        end else begin : g_off
            assign w_interval[c] = 16'd0;
            assign w_ctrl[c]     = '0;
            assign w_count[c]    = 16'd0;
            assign w_fire[c]     = 1'b0;
        end
        assign w_ie[c] = w_ctrl[c].ie;
    end

    // A fire in the same cycle as an ACK or status clear is OR-ed in last and wins.
    assign w_ack_clr  = BUS_INTERRUPT_ACK ? w_ie : 4'b0000;
    assign w_stat_clr = (BUS_WE && (w_off == OFF_STATUS)) ? BUS_DATA[3:0] : 4'b0000;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pending <= 4'b0000;
            r_raise   <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_ack_clr & ~w_stat_clr) | w_fire;
            r_raise   <= |(r_pending & w_ie);
        end
    end

    assign BUS_INTERRUPT_RAISE = r_raise;

`ifdef MTIMER_SNAPSHOT_EN
    logic [7:0] r_shadow;

    always_ff @(posedge CLK) begin
        if (RESET)
            r_shadow <= 8'h00;
        else if (w_rd && w_ch_space && (w_reg == OFF_COUNT[1:0]))
            r_shadow <= w_count[w_ch][15:8];
    end

    assign w_cnthi = r_shadow;
`else
    logic [1:0] r_last_ch;

    always_ff @(posedge CLK) begin
        if (RESET)
            r_last_ch <= 2'd0;
        else if (w_rd && w_ch_space && (w_reg == OFF_COUNT[1:0]))
            r_last_ch <= w_ch;
    end

    assign w_cnthi = w_count[r_last_ch][15:8];
`endif

    always_comb begin
        w_rd_mux = 8'h00;
        if (w_ch_space) begin
            case (w_reg)
                OFF_INT_LO[1:0]: w_rd_mux = w_interval[w_ch][7:0];
                OFF_INT_HI[1:0]: w_rd_mux = w_interval[w_ch][15:8];
                OFF_CTRL[1:0]:   w_rd_mux = {5'b00000, w_ctrl[w_ch]};
                default:         w_rd_mux = w_count[w_ch][7:0];
            endcase
        end else if (w_off == OFF_STATUS) begin
            w_rd_mux = {4'b0000, r_pending};
        end else begin
            w_rd_mux = w_cnthi;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rd_en   <= 1'b0;
            r_rd_data <= 8'h00;
        end else begin
            r_rd_en <= w_rd;
            if (w_rd)
                r_rd_data <= w_rd_mux;
        end
    end

    assign BUS_DATA = r_rd_en ? r_rd_data : 8'hzz;

endmodule

// File: tb/tb_multi_timer.sv
// tb/tb_multi_timer.sv - directed and randomized bench for multi_timer against a spec-level model
module tb_multi_timer;

    localparam int         DIV  = 10;
    localparam int         BASE = 'hE0;
    localparam logic [7:0] IDLE = 8'h00;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       BUS_WE = 1'b0;
    logic       BUS_INTERRUPT_ACK = 1'b0;
    logic [7:0] BUS_ADDR = IDLE;
    logic [7:0] wdata = 8'h00;
    wire  [7:0] BUS_DATA;
    wire        BUS_INTERRUPT_RAISE;

    int checks = 0;
    int errors = 0;

    assign BUS_DATA = BUS_WE ? wdata : 8'hzz;

    multi_timer #(
        .BASE_ADDR(8'hE0), .NUM_CH(4), .CLK_DIV(DIV), .INIT_INTERVAL(16'd100)
    ) dut (
        .CLK(CLK), .RESET(RESET), .BUS_DATA(BUS_DATA), .BUS_ADDR(BUS_ADDR), .BUS_WE(BUS_WE),
        .BUS_INTERRUPT_RAISE(BUS_INTERRUPT_RAISE), .BUS_INTERRUPT_ACK(BUS_INTERRUPT_ACK)
    );

    always #5 CLK = ~CLK;

    // Reference state: what a programmer would believe the timer holds after each clock.
    int         m_int [4];
    int         m_cnt [4];
    bit         m_en [4];
    bit         m_per [4];
    bit         m_ie [4];
    logic [3:0] m_pend;
    bit         m_raise;
    bit         m_rdv;
    logic [7:0] m_rdd;
    logic [7:0] m_shadow;
    int         m_last;
    int         m_presc;

    function automatic logic [7:0] read_val(input int off);
        int c = off / 4;
        if (off < 16) begin
            case (off % 4)
                0:       return 8'(m_int[c]);
                1:       return 8'(m_int[c] >> 8);
                2:       return {5'b00000, m_ie[c], m_per[c], m_en[c]};
                default: return 8'(m_cnt[c]);
            endcase
        end
        if (off == 16) return {4'b0000, m_pend};
`ifdef MTIMER_SNAPSHOT_EN
        return m_shadow;
`else
        return 8'(m_cnt[m_last] >> 8);
`endif
    endfunction

    task automatic model_edge();
        int off;
        bit tick;
        logic [3:0] fired;
        logic [3:0] iem;
        int nxt;
        if (RESET) begin
            for (int c = 0; c < 4; c++) begin
                m_int[c] = 0; m_cnt[c] = 0; m_en[c] = 0; m_per[c] = 0; m_ie[c] = 0;
            end
            m_int[0] = 100; m_en[0] = 1; m_per[0] = 1; m_ie[0] = 1;
            m_pend = 4'h0; m_raise = 0; m_presc = 0; m_rdv = 0; m_rdd = 8'h00;
            m_last = 0; m_shadow = 8'h00;
            return;
        end
        off  = int'(BUS_ADDR) - BASE;
        tick = (m_presc == DIV - 1);
        for (int c = 0; c < 4; c++) iem[c] = m_ie[c];
        m_rdv = !BUS_WE && off >= 0 && off < 18;
        if (m_rdv) begin
            m_rdd = read_val(off);
            if (off < 16 && off % 4 == 3) begin
                m_shadow = 8'(m_cnt[off / 4] >> 8);
                m_last   = off / 4;
            end
        end
        m_raise = |(m_pend & iem);
        fired = 4'h0;
        for (int c = 0; c < 4; c++) begin
            if (tick && m_en[c] && m_int[c] != 0) begin
                nxt = (m_cnt[c] + 1) % 65536;
                if (nxt == m_int[c]) begin
                    fired[c] = 1'b1;
                    m_cnt[c] = 0;
                    if (!m_per[c]) m_en[c] = 0;
                end else begin
                    m_cnt[c] = nxt;
                end
            end
        end
        if (BUS_INTERRUPT_ACK) m_pend = m_pend & ~iem;
        if (BUS_WE && off == 16) m_pend = m_pend & ~wdata[3:0];
        m_pend = m_pend | fired;
        if (BUS_WE && off >= 0 && off < 16) begin
            case (off % 4)
                0: m_int[off / 4] = (m_int[off / 4] & 'hFF00) | int'(wdata);
                1: m_int[off / 4] = (m_int[off / 4] & 'h00FF) | (int'(wdata) << 8);
                2: begin
                    m_en[off / 4]  = wdata[0];
                    m_per[off / 4] = wdata[1];
                    m_ie[off / 4]  = wdata[2];
                end
                default: m_cnt[off / 4] = 0;
            endcase
        end
        m_presc = tick ? 0 : m_presc + 1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        chk("raise", {15'b0, BUS_INTERRUPT_RAISE}, {15'b0, m_raise});
        if (m_rdv) chk("bus_data", {8'b0, BUS_DATA}, {8'b0, m_rdd});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        BUS_ADDR = a; wdata = d; BUS_WE = 1'b1;
        cyc();
        BUS_WE = 1'b0; BUS_ADDR = IDLE;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] v);
        BUS_ADDR = a;
        cyc();
        v = BUS_DATA;
        BUS_ADDR = IDLE;
        cyc();
    endtask

    task automatic ack_pulse();
        BUS_INTERRUPT_ACK = 1'b1;
        cyc();
        BUS_INTERRUPT_ACK = 1'b0;
    endtask

    task automatic wait_pend(input int c, input int limit, input string tag);
        int n = 0;
        while (!m_pend[c] && n < limit) begin cyc(); n++; end
        chk(tag, {15'b0, n < limit}, 16'd1);
    endtask

    task automatic wait_cnt(input int c, input int val, input int limit, input string tag);
        int n = 0;
        while (m_cnt[c] != val && n < limit) begin cyc(); n++; end
        chk(tag, {15'b0, n < limit}, 16'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        bit found;
        int op;
        int off;

        RESET = 1'b1;
        idle(3);
        RESET = 1'b0;

        rd(8'hE0, v); chk("rst_int_lo0", {8'b0, v}, 16'h0064);
        rd(8'hE1, v); chk("rst_int_hi0", {8'b0, v}, 16'h0000);
        rd(8'hE2, v); chk("rst_ctrl0", {8'b0, v}, 16'h0007);
        rd(8'hE6, v); chk("rst_ctrl1", {8'b0, v}, 16'h0000);
        rd(8'hF0, v); chk("rst_status", {8'b0, v}, 16'h0000);
        chk("rst_raise", {15'b0, BUS_INTERRUPT_RAISE}, 16'd0);

        // ch0 fires after 100 ticks; RAISE follows one edge later, ACK drops it one edge after clearing.
        wait_pend(0, 1100, "ch0_fire_bound");
        chk("raise_at_fire", {15'b0, BUS_INTERRUPT_RAISE}, 16'd0);
        cyc();
        chk("raise_after_fire", {15'b0, BUS_INTERRUPT_RAISE}, 16'd1);
        ack_pulse();
        chk("raise_at_ack", {15'b0, BUS_INTERRUPT_RAISE}, 16'd1);
        cyc();
        chk("raise_after_ack", {15'b0, BUS_INTERRUPT_RAISE}, 16'd0);

        // ch1 one-shot with interval 3
        wr(8'hE2, 8'h00);
        wr(8'hE4, 8'h03); wr(8'hE5, 8'h00); wr(8'hE7, 8'h00); wr(8'hE6, 8'h05);
        idle(200);
        rd(8'hE6, v); chk("oneshot_en_cleared", {8'b0, v}, 16'h0004);
        rd(8'hF0, v); chk("oneshot_pending", {8'b0, v}, 16'h0002);
        wr(8'hF0, 8'h02);
        idle(200);
        rd(8'hF0, v); chk("oneshot_no_refire", {8'b0, v}, 16'h0000);

        // ch2 periodic with IE, ch3 periodic without IE
        wr(8'hE8, 8'h05); wr(8'hE9, 8'h00); wr(8'hEB, 8'h00); wr(8'hEA, 8'h07);
        wr(8'hEC, 8'h05); wr(8'hED, 8'h00); wr(8'hEF, 8'h00); wr(8'hEE, 8'h03);
        idle(70);
        wr(8'hEA, 8'h06); wr(8'hEE, 8'h02);
        rd(8'hF0, v); chk("ch23_pending", {8'b0, v}, 16'h000C);
        ack_pulse();
        rd(8'hF0, v); chk("ack_ie_only", {8'b0, v}, 16'h0008);
        wr(8'hF0, 8'h08);
        rd(8'hF0, v); chk("status_w1c", {8'b0, v}, 16'h0000);

        // ACK landing on the same edge as a ch0 fire
        wr(8'hE0, 8'h02); wr(8'hE1, 8'h00); wr(8'hE3, 8'h00); wr(8'hE2, 8'h07);
        wait_pend(0, 100, "ch0_short_fire_bound");
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_presc == DIV - 1 && m_en[0] && ((m_cnt[0] + 1) % 65536) == m_int[0]) begin
                ack_pulse();
                found = 1;
            end else begin
                cyc();
            end
        end
        chk("coincide_found", {15'b0, found}, 16'd1);
        for (int i = 0; i < 3; i++) begin
            chk("raise_held", {15'b0, BUS_INTERRUPT_RAISE}, 16'd1);
            cyc();
        end
        rd(8'hF0, v); chk("fire_beats_ack", {15'b0, v[0]}, 16'd1);
        wr(8'hE2, 8'h00); wr(8'hF0, 8'h0F);
        idle(3);
        chk("raise_cleared", {15'b0, BUS_INTERRUPT_RAISE}, 16'd0);

        // 16-bit count read on ch1
        wr(8'hE4, 8'hE8); wr(8'hE5, 8'h03); wr(8'hE7, 8'h00); wr(8'hE6, 8'h01);
        wait_cnt(1, 300, 3500, "cnt300_bound");
        rd(8'hE7, v); chk("cnt300_lo", {8'b0, v}, 16'h002C);
        rd(8'hF1, v); chk("cnt300_hi", {8'b0, v}, 16'h0001);
        wait_cnt(1, 511, 2500, "cnt511_bound");
        rd(8'hE7, v); chk("cnt511_lo", {8'b0, v}, 16'h00FF);
        wait_cnt(1, 512, 20, "cnt512_bound");
        rd(8'hF1, v);
`ifdef MTIMER_SNAPSHOT_EN
        chk("cnthi_snapshot", {8'b0, v}, 16'h0001);
`else
        chk("cnthi_live", {8'b0, v}, 16'h0002);
`endif
        wr(8'hE6, 8'h00);

        // randomized bus traffic
        for (int k = 0; k < 600; k++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: begin
                    off = $urandom_range(0, 21);
                    if (off < 16 && off % 4 == 0)
                        wr(8'(BASE + off), 8'($urandom_range(0, 12)));
                    else if (off < 16 && off % 4 == 1)
                        wr(8'(BASE + off), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
                    else
                        wr(8'(BASE + off), 8'($urandom));
                end
                3, 4: rd(8'(BASE + $urandom_range(0, 20)), v);
                5:    ack_pulse();
                6:    idle($urandom_range(1, 25));
                default: wr(8'hF0, 8'($urandom));
            endcase
        end

        // RESET mid-count with pending set, coinciding with a write and an ACK
        wr(8'hE0, 8'h02); wr(8'hE1, 8'h00); wr(8'hE3, 8'h00); wr(8'hE2, 8'h07);
        wait_pend(0, 200, "pre_reset_pending_bound");
        RESET = 1'b1; BUS_WE = 1'b1; BUS_ADDR = 8'hE2; wdata = 8'h00; BUS_INTERRUPT_ACK = 1'b1;
        cyc();
        RESET = 1'b0; BUS_WE = 1'b0; BUS_ADDR = IDLE; BUS_INTERRUPT_ACK = 1'b0;
        chk("reset_raise", {15'b0, BUS_INTERRUPT_RAISE}, 16'd0);
        rd(8'hE3, v); chk("reset_count0", {8'b0, v}, 16'h0000);
        rd(8'hE0, v); chk("reset_int_lo0", {8'b0, v}, 16'h0064);
        rd(8'hE2, v); chk("reset_ctrl0", {8'b0, v}, 16'h0007);
        rd(8'hF0, v); chk("reset_status", {8'b0, v}, 16'h0000);
        rd(8'hE6, v); chk("reset_ctrl1", {8'b0, v}, 16'h0000);
        rd(8'hF1, v); chk("reset_cnthi", {8'b0, v}, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
